// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at tail, captures CDB results, retires in order from head.
// Optional ROB_CDB_FWD_EN forwards a same-cycle CDB result onto the source-operand read ports.
module reorder_buffer #(
  parameter int unsigned data_width = 16,
  parameter int unsigned tag_width  = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rob_write_enable,
  input  logic [3:0]                    rob_opcode,
  input  logic [2:0]                    rob_dest,
  input  logic [data_width-1:0]         rob_value_in,
  // CDB_in packs {valid, tag, data}, MSB first
  input  logic [tag_width+data_width:0] CDB_in,
  input  logic [tag_width-1:0]          rob_sr1_read_addr,
  input  logic [tag_width-1:0]          rob_sr2_read_addr,
  output logic                          rob_full,
  output logic [tag_width-1:0]          rob_addr,
  output logic [data_width-1:0]         rob_sr1_value_out,
  output logic [data_width-1:0]         rob_sr2_value_out,
  output logic                          rob_sr1_valid_out,
  output logic                          rob_sr2_valid_out,
  output logic                          commit_we,
  output logic [2:0]                    commit_dest,
  output logic [data_width-1:0]         commit_value,
  output logic [tag_width-1:0]          commit_tag,
  output logic                          flush,
  output logic [data_width-1:0]         flush_pc
);

  localparam int unsigned Depth = 1 << tag_width;
  localparam int unsigned CntW  = tag_width + 1;
  localparam logic [3:0]  OpBr  = 4'b0000;
  localparam logic [3:0]  OpLea = 4'b1110;

  logic                  cdb_valid;
  logic [tag_width-1:0]  cdb_tag;
  logic [data_width-1:0] cdb_data;

  assign {cdb_valid, cdb_tag, cdb_data} = CDB_in;

  logic [Depth-1:0]      valid_q, valid_d;
  logic [Depth-1:0]      ready_q, ready_d;
  logic [Depth-1:0]      mispred_q, mispred_d;
  logic [3:0]            opcode_q [Depth];
  logic [3:0]            opcode_d [Depth];
  logic [2:0]            dest_q [Depth];
  logic [2:0]            dest_d [Depth];
  logic [data_width-1:0] value_q [Depth];
  logic [data_width-1:0] value_d [Depth];
  logic [tag_width-1:0]  head_q, head_d;
  logic [tag_width-1:0]  tail_q, tail_d;
  logic [CntW-1:0]       count_q, count_d;

  logic alloc;
  logic retire;
  logic head_is_br;

  assign rob_full   = (count_q == CntW'(Depth));
  assign rob_addr   = tail_q;
  assign alloc      = rob_write_enable && !rob_full;
  assign retire     = valid_q[head_q] && ready_q[head_q];
  assign head_is_br = (opcode_q[head_q] == OpBr);

  always_comb begin
    commit_we    = 1'b0;
    commit_dest  = '0;
    commit_value = '0;
    commit_tag   = '0;
    flush        = 1'b0;
    flush_pc     = '0;
    if (retire) begin
      if (head_is_br) begin
        flush    = mispred_q[head_q];
        flush_pc = mispred_q[head_q] ? value_q[head_q] : '0;
      end else begin
        commit_we    = 1'b1;
        commit_dest  = dest_q[head_q];
        commit_value = value_q[head_q];
        commit_tag   = head_q;
      end
    end
  end

  always_comb begin
    valid_d   = valid_q;
    ready_d   = ready_q;
    mispred_d = mispred_q;
    opcode_d  = opcode_q;
    dest_d    = dest_q;
    value_d   = value_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (flush) begin
      // Mispredicted branch: everything younger is wrong-path, drop it all.
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (retire) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
      end
      if (cdb_valid && valid_q[cdb_tag] && !ready_q[cdb_tag]) begin
        ready_d[cdb_tag] = 1'b1;
        if (opcode_q[cdb_tag] == OpBr) begin
          mispred_d[cdb_tag] = cdb_data[0];
        end else begin
          value_d[cdb_tag] = cdb_data;
        end
      end
      if (alloc) begin
        valid_d[tail_q]   = 1'b1;
        ready_d[tail_q]   = (rob_opcode == OpLea);
        mispred_d[tail_q] = 1'b0;
        opcode_d[tail_q]  = rob_opcode;
        dest_d[tail_q]    = rob_dest;
        value_d[tail_q]   = rob_value_in;
        tail_d            = tail_q + 1'b1;
      end
      count_d = count_q + CntW'(alloc) - CntW'(retire);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= '0;
      ready_q   <= '0;
      mispred_q <= '0;
      opcode_q  <= '{default: '0};
      dest_q    <= '{default: '0};
      value_q   <= '{default: '0};
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      mispred_q <= mispred_d;
      opcode_q  <= opcode_d;
      dest_q    <= dest_d;
      value_q   <= value_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    rob_sr1_value_out = value_q[rob_sr1_read_addr];
    rob_sr1_valid_out = valid_q[rob_sr1_read_addr] && ready_q[rob_sr1_read_addr];
    rob_sr2_value_out = value_q[rob_sr2_read_addr];
    rob_sr2_valid_out = valid_q[rob_sr2_read_addr] && ready_q[rob_sr2_read_addr];
`ifdef ROB_CDB_FWD_EN
    if (cdb_valid && cdb_tag == rob_sr1_read_addr && valid_q[rob_sr1_read_addr]
        && !ready_q[rob_sr1_read_addr]) begin
      rob_sr1_value_out = cdb_data;
      rob_sr1_valid_out = 1'b1;
    end
    if (cdb_valid && cdb_tag == rob_sr2_read_addr && valid_q[rob_sr2_read_addr]
        && !ready_q[rob_sr2_read_addr]) begin
      rob_sr2_value_out = cdb_data;
      rob_sr2_valid_out = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: fill/full, commit order, branch flush, read ports, reset.
module tb_reorder_buffer;

  localparam logic [3:0] OpBr  = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpLdr = 4'b0110;
  localparam logic [3:0] OpLea = 4'b1110;
`ifdef ROB_CDB_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        rob_write_enable;
  logic [3:0]  rob_opcode;
  logic [2:0]  rob_dest;
  logic [15:0] rob_value_in;
  logic [19:0] cdb_in;
  logic [2:0]  sr1_addr, sr2_addr;
  logic        rob_full;
  logic [2:0]  rob_addr;
  logic [15:0] sr1_value, sr2_value;
  logic        sr1_valid, sr2_valid;
  logic        commit_we;
  logic [2:0]  commit_dest;
  logic [15:0] commit_value;
  logic [2:0]  commit_tag;
  logic        flush;
  logic [15:0] flush_pc;

  int unsigned vec_cnt;
  int unsigned err_cnt;

  reorder_buffer dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .rob_write_enable  (rob_write_enable),
    .rob_opcode        (rob_opcode),
    .rob_dest          (rob_dest),
    .rob_value_in      (rob_value_in),
    .CDB_in            (cdb_in),
    .rob_sr1_read_addr (sr1_addr),
    .rob_sr2_read_addr (sr2_addr),
    .rob_full          (rob_full),
    .rob_addr          (rob_addr),
    .rob_sr1_value_out (sr1_value),
    .rob_sr2_value_out (sr2_value),
    .rob_sr1_valid_out (sr1_valid),
    .rob_sr2_valid_out (sr2_valid),
    .commit_we         (commit_we),
    .commit_dest       (commit_dest),
    .commit_value      (commit_value),
    .commit_tag        (commit_tag),
    .flush             (flush),
    .flush_pc          (flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then clear single-cycle strobes.
  task automatic cyc();
    @(posedge clk);
    #1;
    rob_write_enable = 1'b0;
    cdb_in           = '0;
  endtask

  task automatic alloc(input logic [3:0] op, input logic [2:0] dst, input logic [15:0] val);
    rob_write_enable = 1'b1;
    rob_opcode       = op;
    rob_dest         = dst;
    rob_value_in     = val;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [15:0] data);
    cdb_in = {1'b1, tag, data};
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    reset_n = 1'b0;
    rob_write_enable = 1'b0;
    rob_opcode = '0;
    rob_dest = '0;
    rob_value_in = '0;
    cdb_in = '0;
    sr1_addr = '0;
    sr2_addr = '0;
    #3;
    check("rst_full", rob_full, 0);
    check("rst_addr", rob_addr, 0);
    check("rst_we", commit_we, 0);
    check("rst_flush", flush, 0);
    check("rst_fpc", flush_pc, 0);
    check("rst_cval", commit_value, 0);
    check("rst_sr1v", sr1_valid, 0);
    #9 reset_n = 1'b1;

    // Fill with eight ADDs, no CDB traffic.
    for (int i = 0; i < 8; i++) begin
      alloc(OpAdd, 3'(i), 16'h0000);
      cyc();
      check("fill_addr", rob_addr, (i + 1) % 8);
      check("fill_full", rob_full, (i == 7) ? 1 : 0);
    end
    alloc(OpAdd, 3'd0, 16'hBEEF);
    cyc();
    check("ovf_addr", rob_addr, 0);
    check("ovf_full", rob_full, 1);
    check("ovf_val", sr1_value, 16'h0000);

    // Full, head completes; write while full is dropped as head retires.
    cdb(3'd0, 16'h0A00);
    cyc();
    check("fullc_we", commit_we, 1);
    check("fullc_tag", commit_tag, 0);
    check("fullc_val", commit_value, 16'h0A00);
    alloc(OpAdd, 3'd0, 16'hBEEF);
    cdb(3'd1, 16'h0005);
    cyc();
    check("fullc_full", rob_full, 0);
    check("fullc_addr", rob_addr, 0);
    check("fullc_sr1v", sr1_valid, 0);
    check("c1_we", commit_we, 1);
    check("c1_tag", commit_tag, 1);
    check("c1_val", commit_value, 16'h0005);

    // Asynchronous reset mid-cycle kills the pending commit immediately.
    #2 reset_n = 1'b0;
    #1;
    check("arst_we", commit_we, 0);
    check("arst_full", rob_full, 0);
    check("arst_addr", rob_addr, 0);
    #3 reset_n = 1'b1;
    cyc();

    // Single ADD R3 completes and commits one cycle later.
    sr1_addr = 3'd0;
    alloc(OpAdd, 3'd3, 16'h0000);
    cyc();
    check("add_addr", rob_addr, 1);
    check("add_sr1v", sr1_valid, 0);
    cdb(3'd0, 16'h1234);
    #1;
    check("add_nocommit", commit_we, 0);
    cyc();
    check("add_we", commit_we, 1);
    check("add_dest", commit_dest, 3);
    check("add_val", commit_value, 16'h1234);
    check("add_tag", commit_tag, 0);
    check("add_sr1v2", sr1_valid, 1);
    check("add_sr1d", sr1_value, 16'h1234);
    cyc();
    check("add_done", commit_we, 0);
    check("add_sr1v3", sr1_valid, 0);

    // Out-of-order completion, in-order retirement.
    alloc(OpAdd, 3'd1, 16'h0000);
    cyc();
    alloc(OpLdr, 3'd2, 16'h0000);
    cyc();
    sr2_addr = 3'd2;
    cdb(3'd2, 16'h2222);
    cyc();
    check("ooo_hold", commit_we, 0);
    check("ooo_sr2v", sr2_valid, 1);
    cdb(3'd1, 16'h1111);
    cyc();
    check("ooo_we1", commit_we, 1);
    check("ooo_tag1", commit_tag, 1);
    check("ooo_val1", commit_value, 16'h1111);
    check("ooo_dst1", commit_dest, 1);
    cyc();
    check("ooo_we2", commit_we, 1);
    check("ooo_tag2", commit_tag, 2);
    check("ooo_val2", commit_value, 16'h2222);
    check("ooo_dst2", commit_dest, 2);
    cyc();
    check("ooo_idle", commit_we, 0);

    // Mispredicted BR at entry 3 with younger entries 4 and 5.
    alloc(OpBr, 3'd0, 16'h3040);
    cyc();
    alloc(OpAdd, 3'd5, 16'h0000);
    cyc();
    alloc(OpAdd, 3'd6, 16'h0000);
    cyc();
    sr1_addr = 3'd4;
    cdb(3'd4, 16'h4444);
    #1;
    check("fwd_v", sr1_valid, FwdEn ? 1 : 0);
    check("fwd_d", sr1_value, FwdEn ? 16'h4444 : 16'h0000);
    cyc();
    check("fwd_v2", sr1_valid, 1);
    check("fwd_d2", sr1_value, 16'h4444);
    cdb(3'd3, 16'h0001);
    #1;
    check("br_noflush", flush, 0);
    cyc();
    check("br_flush", flush, 1);
    check("br_fpc", flush_pc, 16'h3040);
    check("br_we", commit_we, 0);
    alloc(OpAdd, 3'd0, 16'h7777);
    cdb(3'd5, 16'h5555);
    sr2_addr = 3'd5;
    cyc();
    check("fl_addr", rob_addr, 0);
    check("fl_flush", flush, 0);
    check("fl_sr1v", sr1_valid, 0);
    check("fl_sr2v", sr2_valid, 0);
    check("fl_full", rob_full, 0);

    // Correctly predicted BR retires silently; LEA is ready on allocation.
    alloc(OpBr, 3'd0, 16'h5000);
    cyc();
    sr1_addr = 3'd1;
    cdb(3'd0, 16'h0000);
    alloc(OpLea, 3'd7, 16'h0ABC);
    cyc();
    check("lea_sr1v", sr1_valid, 1);
    check("brok_we", commit_we, 0);
    check("brok_flush", flush, 0);
    cyc();
    check("lea_we", commit_we, 1);
    check("lea_dest", commit_dest, 7);
    check("lea_val", commit_value, 16'h0ABC);
    check("lea_tag", commit_tag, 1);
    cyc();
    check("end_we", commit_we, 0);
    check("end_addr", rob_addr, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
